pixel_writer: RTL and testbench
===============================

# pixel_writer

Downstream consumer of the draw units (DrawCircle, line and triangle drawers). It accepts one (X, Y) point per cycle from the active draw unit and buffers it in a small FIFO. It clips points outside the framebuffer and converts each in-range point to a linear framebuffer address. It then issues single-cycle writes to the framebuffer port, yielding to the scan-out reader whenever FB_BUSY is high.

## Interface
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- DEPTH, 8, point FIFO depth; power of two, at least 2
- ADDR_W, 15, framebuffer address width; FB_W*FB_H <= 2^ADDR_W
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  synchronous, active-low reset
- PT_VALID  in  1  draw unit presents a point on X_In/Y_In/COLOR
- X_In  in  8  point X coordinate, unsigned
- Y_In  in  8  point Y coordinate, unsigned
- COLOR  in  3  pixel colour (RGB, 1 bit each)
- PT_READY  out  1  FIFO can accept a point this cycle
- FB_BUSY  in  1  framebuffer port owned by scan-out; no write allowed
- FB_WE  out  1  framebuffer write strobe, one cycle per pixel
- FB_ADDR  out  ADDR_W  write address, Y*FB_W + X
- FB_DATA  out  3  write colour
- CLIP_CNT  out  16  count of discarded out-of-range points, saturating
- IDLE  out  1  FIFO empty and FSM in S_IDLE

## Operation
- Push: occurs on an edge where PT_VALID && PT_READY. It stores {COLOR, Y_In, X_In}.
- PT_READY = (count != DEPTH). It is combinational from the count register.
- Simultaneous push and pop: count is unchanged. Push while full does not occur because PT_READY is 0; the draw unit must hold its point.
- Pointers wrap modulo DEPTH. Count is a log2(DEPTH)+1 bit register.
- FSM states and transitions:
  - S_IDLE: if the FIFO is non-empty, pop the head into registers px, py, pc and go to S_CALC. Otherwise stay.
  - S_CALC: if px >= FB_W or py >= FB_H, increment CLIP_CNT (holds at 16'hFFFF) and go to S_IDLE. Otherwise register FB_ADDR <= py*FB_W + px (16-bit product, truncated to ADDR_W) and FB_DATA <= pc, then go to S_WRITE.
  - S_WRITE: FB_WE = ARESETN && (state == S_WRITE) && !FB_BUSY. When FB_WE is 1, go to S_IDLE. Otherwise stay, holding FB_ADDR and FB_DATA stable.
- Points are written strictly in push order. No point is lost or duplicated.
- IDLE = (state == S_IDLE) && (count == 0).
- Reset values: state S_IDLE, count 0, pointers 0, FB_ADDR 0, FB_DATA 0, CLIP_CNT 0.
- Resulting output values after reset: FB_WE 0, PT_READY 1, IDLE 1.

## Timing
- Latency: a point pushed at edge E0 into an empty, idle block is popped at E1 and its address is registered at E2. FB_WE is high in the cycle after E2 if FB_BUSY is low. The write completes at E3.
- Throughput: one pixel per 3 cycles with FB_BUSY low. Clipped points take 2 cycles and produce no FB_WE.
- FB_BUSY is sampled combinationally during S_WRITE. Each extra busy cycle adds one cycle of stall.
- FB_WE never stays high for 2 consecutive cycles.
- Reset mid-operation:
  - FB_WE is forced to 0 in any cycle where ARESETN is 0.
  - The FIFO contents and the in-flight point are discarded.
  - No write is issued after reset for a point pushed before reset.
- A push in the same cycle as ARESETN = 0 is dropped.

## Test plan
- Single in-range point: push (5,0), COLOR 3'b101, FB_BUSY 0 -> exactly one FB_WE, 3 cycles after the push edge, with FB_ADDR 5 and FB_DATA 3'b101. IDLE returns to 1 on the following cycle.
- Corner addresses: push (0,119) then (159,119) -> FB_WE with FB_ADDR 19040, then FB_ADDR 19199, in that order.
- Clipping: push (160,0), (0,120), (255,255) -> no FB_WE and CLIP_CNT = 3. Pre-load CLIP_CNT to 16'hFFFF, then push one more clipped point -> CLIP_CNT stays 16'hFFFF.
- Backpressure burst: the draw unit holds PT_VALID high for 20 distinct points and obeys PT_READY -> PT_READY falls when 8 points are queued. Exactly 20 FB_WE pulses occur, in push order, with correct addresses.
- Framebuffer contention: FB_BUSY high for 20 cycles while in S_WRITE -> FB_WE stays 0 and FB_ADDR/FB_DATA stay stable. One FB_WE occurs on the first cycle with FB_BUSY low.
- Reset mid-write: queue 4 points, then assert ARESETN = 0 for 1 cycle while in S_WRITE -> FB_WE is 0 in that cycle and never pulses afterwards. PT_READY = 1, IDLE = 1, CLIP_CNT = 0.

Source files
------------

// File: rtl/pixel_writer_if.sv
// Point-in / framebuffer-out signal bundle for pixel_writer.
// The slave modport is the pixel_writer side; the master modport is the draw unit / framebuffer side.
interface pixel_writer_if #(
    parameter int ADDR_W = 15
);
    logic              PT_VALID;
    logic [7:0]        X_In;
    logic [7:0]        Y_In;
    logic [2:0]        COLOR;
    logic              PT_READY;
    logic              FB_BUSY;
    logic              FB_WE;
    logic [ADDR_W-1:0] FB_ADDR;
    logic [2:0]        FB_DATA;

    modport slave (
        input  PT_VALID, X_In, Y_In, COLOR, FB_BUSY,
        output PT_READY, FB_WE, FB_ADDR, FB_DATA
    );

    modport master (
        output PT_VALID, X_In, Y_In, COLOR, FB_BUSY,
        input  PT_READY, FB_WE, FB_ADDR, FB_DATA
    );
endinterface

// File: rtl/pixel_writer.sv
// Buffers draw-unit points in a small FIFO, clips them to the framebuffer and
// issues one single-cycle write per in-range point, yielding while FB_BUSY is high.
module pixel_writer #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 15
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    pixel_writer_if.slave bus,
    output logic [15:0]  CLIP_CNT,
    output logic         IDLE
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 19;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WRITE
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] prod;
        prod = 16'(y) * 16'(FB_W) + 16'(x);
        return ADDR_W'(prod);
    endfunction

    state_t              state_q;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ENT_W-1:0]    mem_q [DEPTH];
    logic [ENT_W-1:0]    head;
    logic [7:0]          px_q, py_q;
    logic [2:0]          pc_q;
    logic [ADDR_W-1:0]   fb_addr_q;
    logic [2:0]          fb_data_q;
    logic [15:0]         clip_cnt_q;
    logic                push, pop, we, clipped;

    assign bus.PT_READY = (count_q != CNT_W'(DEPTH));
    assign push         = bus.PT_VALID && bus.PT_READY;
    assign pop          = (state_q == S_IDLE) && (count_q != '0);
    assign head         = mem_q[rd_ptr_q];
    assign clipped      = (int'(px_q) >= FB_W) || (int'(py_q) >= FB_H);
    assign we           = ARESETN && (state_q == S_WRITE) && !bus.FB_BUSY;

    assign bus.FB_WE    = we;
    assign bus.FB_ADDR  = fb_addr_q;
    assign bus.FB_DATA  = fb_data_q;
    assign CLIP_CNT     = clip_cnt_q;
    assign IDLE         = (state_q == S_IDLE) && (count_q == '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= {bus.COLOR, bus.Y_In, bus.X_In};
    end

    // Write address and colour are held stable for the whole stall in S_WRITE.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q    <= S_IDLE;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            clip_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {pc_q, py_q, px_q} <= head;
                        state_q            <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (clipped) begin
                        clip_cnt_q <= sat_inc(clip_cnt_q);
                        state_q    <= S_IDLE;
                    end else begin
                        fb_addr_q <= lin_addr(px_q, py_q);
                        fb_data_q <= pc_q;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (we) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: latency, corner addresses, clipping,
// backpressure, framebuffer contention and reset during a write.
module tb_pixel_writer;
    localparam int ADDR_W = 15;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [15:0] CLIP_CNT;
    logic        IDLE;

    pixel_writer_if #(.ADDR_W(ADDR_W)) bus ();

    pixel_writer #(.FB_W(160), .FB_H(120), .DEPTH(8), .ADDR_W(ADDR_W)) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .bus      (bus.slave),
        .CLIP_CNT (CLIP_CNT),
        .IDLE     (IDLE)
    );

    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    int we_cyc   = 0;
    int push_cyc = 0;
    logic prev_we = 1'b0;
    logic [17:0] wr_q[$];
    logic [17:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    // Captures every write and checks strobes are never back to back.
    always @(negedge ACLK) begin
        if (bus.FB_WE === 1'b1) begin
            check_val("we_gap", {31'd0, prev_we}, 32'd0);
            wr_q.push_back({bus.FB_ADDR, bus.FB_DATA});
            we_cnt++;
            we_cyc = cyc;
        end
        prev_we = bus.FB_WE;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic push_point(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
        int n;
        bus.PT_VALID = 1'b1;
        bus.X_In     = x;
        bus.Y_In     = y;
        bus.COLOR    = c;
        n = 0;
        while (!bus.PT_READY && n < 200) begin
            @(posedge ACLK); #1;
            n++;
        end
        check_val("push_ready", {31'd0, bus.PT_READY}, 32'd1);
        @(posedge ACLK); #1;
        push_cyc     = cyc;
        bus.PT_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge ACLK);
        while (!IDLE && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        check_val("idle_reached", {31'd0, IDLE}, 32'd1);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check_val({tag, "_count"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check_val({tag, "_addr"}, 32'(wr_q[k][17:3]), 32'(exp_q[k][17:3]));
            check_val({tag, "_data"}, 32'(wr_q[k][2:0]), 32'(exp_q[k][2:0]));
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int   accepted;
        int   base;
        int   n;
        logic saw_low;

        ARESETN      = 1'b0;
        bus.PT_VALID = 1'b0;
        bus.X_In     = '0;
        bus.Y_In     = '0;
        bus.COLOR    = '0;
        bus.FB_BUSY  = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_val("rst_we",    {31'd0, bus.FB_WE},    32'd0);
        check_val("rst_ready", {31'd0, bus.PT_READY}, 32'd1);
        check_val("rst_idle",  {31'd0, IDLE},         32'd1);
        check_val("rst_clip",  32'(CLIP_CNT),         32'd0);
        check_val("rst_addr",  32'(bus.FB_ADDR),      32'd0);
        check_val("rst_data",  32'(bus.FB_DATA),      32'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Single point: strobe in the cycle after E2, IDLE back after E3.
        push_point(8'd5, 8'd0, 3'b101);
        exp_q.push_back({15'd5, 3'b101});
        wait_idle();
        check_val("single_idle_lat", cyc - push_cyc, 32'd3);
        check_val("single_we_lat", we_cyc - push_cyc, 32'd2);
        check_writes("single");

        // Corner addresses.
        push_point(8'd0, 8'd119, 3'b001);
        push_point(8'd159, 8'd119, 3'b110);
        exp_q.push_back({15'd19040, 3'b001});
        exp_q.push_back({15'd19199, 3'b110});
        wait_idle();
        check_writes("corner");

        // Clipping and counter saturation.
        push_point(8'd160, 8'd0, 3'b111);
        push_point(8'd0, 8'd120, 3'b111);
        push_point(8'd255, 8'd255, 3'b111);
        wait_idle();
        check_val("clip_cnt3", 32'(CLIP_CNT), 32'd3);
        check_writes("clip");
        @(negedge ACLK);
        force dut.clip_cnt_q = 16'hFFFE;
        #1 release dut.clip_cnt_q;
        check_val("clip_preload", 32'(CLIP_CNT), 32'h0000FFFE);
        push_point(8'd200, 8'd5, 3'b010);
        wait_idle();
        check_val("clip_max", 32'(CLIP_CNT), 32'h0000FFFF);
        push_point(8'd5, 8'd200, 3'b010);
        wait_idle();
        check_val("clip_sat", 32'(CLIP_CNT), 32'h0000FFFF);
        check_writes("clip_sat");

        // Burst of 20: first point stalls in S_WRITE, so 9 are accepted before PT_READY drops.
        bus.FB_BUSY = 1'b1;
        accepted = 0;
        saw_low  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.PT_VALID = 1'b1;
            bus.X_In     = 8'(i * 7);
            bus.Y_In     = 8'(i * 5 + 1);
            bus.COLOR    = 3'(i);
            exp_q.push_back({15'((i * 5 + 1) * 160 + i * 7), 3'(i)});
            n = 0;
            while (!bus.PT_READY && n < 200) begin
                if (!saw_low) begin
                    saw_low = 1'b1;
                    check_val("burst_full_at", accepted, 32'd9);
                    bus.FB_BUSY = 1'b0;
                end
                @(posedge ACLK); #1;
                n++;
            end
            @(posedge ACLK); #1;
            accepted++;
        end
        bus.PT_VALID = 1'b0;
        bus.FB_BUSY  = 1'b0;
        check_val("burst_saw_full", {31'd0, saw_low}, 32'd1);
        wait_idle();
        check_writes("burst");

        // Framebuffer contention: 20 busy cycles in S_WRITE.
        bus.FB_BUSY = 1'b1;
        push_point(8'd10, 8'd3, 3'b011);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            check_val("busy_we",   {31'd0, bus.FB_WE}, 32'd0);
            check_val("busy_addr", 32'(bus.FB_ADDR),   32'd490);
            check_val("busy_data", 32'(bus.FB_DATA),   32'd3);
        end
        @(posedge ACLK); #1;
        bus.FB_BUSY = 1'b0;
        @(negedge ACLK);
        check_val("busy_release_we", {31'd0, bus.FB_WE}, 32'd1);
        exp_q.push_back({15'd490, 3'b011});
        wait_idle();
        check_writes("busy");

        // Reset while a write is pending, with a push offered during reset.
        bus.FB_BUSY = 1'b1;
        push_point(8'd1, 8'd2, 3'b001);
        push_point(8'd3, 8'd4, 3'b010);
        push_point(8'd5, 8'd6, 3'b011);
        push_point(8'd7, 8'd8, 3'b100);
        ARESETN      = 1'b0;
        bus.FB_BUSY  = 1'b0;
        bus.PT_VALID = 1'b1;
        bus.X_In     = 8'd9;
        bus.Y_In     = 8'd9;
        bus.COLOR    = 3'b111;
        @(negedge ACLK);
        check_val("rstw_we", {31'd0, bus.FB_WE}, 32'd0);
        base = we_cnt;
        @(posedge ACLK); #1;
        ARESETN      = 1'b1;
        bus.PT_VALID = 1'b0;
        repeat (20) @(negedge ACLK);
        check_val("rstw_no_write", we_cnt, base);
        check_val("rstw_ready", {31'd0, bus.PT_READY}, 32'd1);
        check_val("rstw_idle",  {31'd0, IDLE},         32'd1);
        check_val("rstw_clip",  32'(CLIP_CNT),         32'd0);
        check_writes("rstw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
